cpu_pc_unit: RTL and testbench

- 16-bit program counter for the NES 6502 core.
- Produces the fetch address consumed by the CPU's address/data register stage. Takes byte loads from the data bus for JMP, vectors and RTS/RTI.
- Implements 6502 relative-branch timing. Sign-extended offset is added to PCL first. A second cycle fixes PCH only on page cross, so the sequencer sees the extra cycle.

---
 rtl/cpu_pc_unit.sv | 117 +++++++++++
 tb/tb_cpu_pc_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_pc_unit.sv
// ---------------------------------------------------------------------------
// cpu_pc_unit
//   16-bit program counter for the NES 6502 core. Supplies the fetch address
//   to the address/data register stage. It also accepts byte loads from the
//   internal data bus for JMP, vectors and RTS/RTI. It implements 6502
//   relative-branch timing: the offset is added to PCL first, and a second
//   (fix) cycle corrects PCH only when the branch crosses a page.
//
// Parameters
//   RESET_PC   : pc value after reset. The reset-vector fetch overwrites it
//                through load_lo/load_hi.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset; wins over enable
//   enable     in   CPU cycle enable; all state holds while low
//   inc        in   pc <= pc + 1 (16-bit wrap)
//   load_lo    in   pc[7:0]  <= data_in
//   load_hi    in   pc[15:8] <= data_in
//   data_in    in   [7:0] byte from the internal data bus
//   branch     in   start a taken relative branch
//   offset     in   [7:0] signed two's-complement branch offset
//   pc         out  [15:0] current program counter (direct register)
//   busy       out  fix cycle pending; commands are ignored
//   page_cross out  high for the one enabled cycle in which pc shows the
//                   intermediate (wrong-page) address
// ---------------------------------------------------------------------------
module cpu_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        inc,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [7:0]  data_in,
  input  logic        branch,
  input  logic [7:0]  offset,
  output logic [15:0] pc,
  output logic        busy,
  output logic        page_cross
);

  typedef enum logic {
    IDLE = 1'b0,
    FIX  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        dir_down_q, dir_down_d;   // 1: PCH decrements in FIX
  logic        cross_q, cross_d;
  logic [8:0]  lo_sum;

  // PCL plus the raw offset byte. Bit 8 is the carry out of PCL. Together
  // with the offset sign it tells whether PCH must move.
  assign lo_sum = {1'b0, pc_q[7:0]} + {1'b0, offset};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dir_down_d = dir_down_q;
    cross_d    = cross_q;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (branch) begin
            pc_d[7:0] = lo_sum[7:0];
            if (!offset[7] && lo_sum[8]) begin
              dir_down_d = 1'b0;
              cross_d    = 1'b1;
              state_d    = FIX;
            end else if (offset[7] && !lo_sum[8]) begin
              dir_down_d = 1'b1;
              cross_d    = 1'b1;
              state_d    = FIX;
            end
          end else if (load_lo || load_hi) begin
            if (load_lo) pc_d[7:0]  = data_in;
            if (load_hi) pc_d[15:8] = data_in;
          end else if (inc) begin
            pc_d = pc_q + 16'd1;
          end
        end
        FIX: begin
          // Commands presented here are dropped, not queued.
          pc_d[15:8] = pc_q[15:8] + (dir_down_q ? 8'hFF : 8'h01);
          cross_d    = 1'b0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      dir_down_q <= 1'b0;
      cross_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dir_down_q <= dir_down_d;
      cross_q    <= cross_d;
    end
  end

  assign pc         = pc_q;
  assign page_cross = cross_q;
  // busy has the same timing as page_cross. It is high exactly while the
  // fix cycle is pending.
  assign busy       = (state_q == FIX);

endmodule

// File: tb/tb_cpu_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_cpu_pc_unit
//   Self-checking bench for cpu_pc_unit (RESET_PC = 16'hFFFC). It runs
//   directed scenarios and then randomized traffic. The reference model works
//   on the full 16-bit branch target and holds any needed PCH correction as a
//   pending value that lands on the next enabled cycle.
// ---------------------------------------------------------------------------
module tb_cpu_pc_unit;

  localparam logic [15:0] RST_PC = 16'hFFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0, enable = 1'b0, inc = 1'b0;
  logic        load_lo = 1'b0, load_hi = 1'b0, branch = 1'b0;
  logic [7:0]  data_in = '0, offset = '0;
  logic [15:0] pc;
  logic        busy, page_cross;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state
  logic [15:0] m_pc = '0;
  logic        m_pending = 1'b0;
  logic [15:0] m_target = '0;

  cpu_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .inc        (inc),
    .load_lo    (load_lo),
    .load_hi    (load_hi),
    .data_in    (data_in),
    .branch     (branch),
    .offset     (offset),
    .pc         (pc),
    .busy       (busy),
    .page_cross (page_cross)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One behavioural step: the effect of the current inputs at the next edge.
  task automatic model_step();
    logic [15:0] tgt;
    if (reset) begin
      m_pc      = RST_PC;
      m_pending = 1'b0;
    end else if (enable) begin
      if (m_pending) begin
        m_pc      = m_target;
        m_pending = 1'b0;
      end else if (branch) begin
        tgt = m_pc + {{8{offset[7]}}, offset};
        if (tgt[15:8] != m_pc[15:8]) begin
          m_pc      = {m_pc[15:8], tgt[7:0]};
          m_target  = tgt;
          m_pending = 1'b1;
        end else begin
          m_pc = tgt;
        end
      end else if (load_lo || load_hi) begin
        if (load_lo) m_pc[7:0]  = data_in;
        if (load_hi) m_pc[15:8] = data_in;
      end else if (inc) begin
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  // Drive on the falling edge, step the model, then sample 1 ns after the
  // rising edge and compare everything.
  task automatic cyc(input logic r, input logic en, input logic i,
                     input logic lo, input logic hi, input logic [7:0] d,
                     input logic br, input logic [7:0] off);
    @(negedge clk);
    reset = r; enable = en; inc = i; load_lo = lo; load_hi = hi;
    data_in = d; branch = br; offset = off;
    model_step();
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("busy", {15'd0, busy}, {15'd0, m_pending});
    check("page_cross", {15'd0, page_cross}, {15'd0, m_pending});
  endtask

  task automatic load_pc(input logic [15:0] v);
    cyc(0, 1, 0, 1, 0, v[7:0], 0, 8'h00);
    cyc(0, 1, 0, 0, 1, v[15:8], 0, 8'h00);
  endtask

  initial begin
    // reset wins over enable=0
    cyc(1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    check("rst_pc", pc, 16'hFFFC);
    check("rst_busy", {15'd0, busy}, 16'd0);
    cyc(0, 1, 0, 1, 0, 8'h34, 0, 8'h00);
    cyc(0, 1, 0, 0, 1, 8'h12, 0, 8'h00);
    check("load_1234", pc, 16'h1234);

    // full-address wrap on inc
    load_pc(16'hFFFF);
    cyc(0, 1, 1, 0, 0, 8'h00, 0, 8'h00);
    check("inc_wrap", pc, 16'h0000);

    // branch within the page
    load_pc(16'h1080);
    cyc(0, 1, 0, 0, 0, 8'h00, 1, 8'h10);
    check("br_nocross", pc, 16'h1090);

    // crossing up, inc during fix ignored
    load_pc(16'h10F0);
    cyc(0, 1, 0, 0, 0, 8'h00, 1, 8'h20);
    check("up_c1_pc", pc, 16'h1010);
    check("up_c1_pcross", {15'd0, page_cross}, 16'd1);
    cyc(0, 1, 1, 0, 0, 8'h00, 0, 8'h00);
    check("up_c2_pc", pc, 16'h1110);
    check("up_c2_busy", {15'd0, busy}, 16'd0);

    // crossing down
    load_pc(16'h1005);
    cyc(0, 1, 0, 0, 0, 8'h00, 1, 8'hF0);
    check("dn_c1_pc", pc, 16'h10F5);
    cyc(0, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    check("dn_c2_pc", pc, 16'h0FF5);

    // enable dropped during fix
    load_pc(16'h20F0);
    cyc(0, 1, 0, 0, 0, 8'h00, 1, 8'h20);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1, 1, 8'h55, 1, 8'h01);
    check("hold_pc", pc, 16'h2010);
    check("hold_busy", {15'd0, busy}, 16'd1);
    cyc(0, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    check("resume_pc", pc, 16'h2110);

    // load both + inc together
    cyc(0, 1, 1, 1, 1, 8'hAB, 0, 8'h00);
    check("load_both", pc, 16'hABAB);

    // PCH wrap in fix: FF -> 00
    load_pc(16'hFFF0);
    cyc(0, 1, 0, 0, 0, 8'h00, 1, 8'h20);
    cyc(0, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    check("pch_wrap", pc, 16'h0010);

    // reset mid-fix
    load_pc(16'h30F0);
    cyc(0, 1, 0, 0, 0, 8'h00, 1, 8'h40);
    cyc(1, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    check("rst_fix_pc", pc, 16'hFFFC);
    check("rst_fix_busy", {15'd0, busy}, 16'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, en, i, lo, hi, br;
      r  = ($urandom_range(0, 63) == 0);
      en = ($urandom_range(0, 7) != 0);
      i  = $urandom_range(0, 1);
      lo = ($urandom_range(0, 5) == 0);
      hi = ($urandom_range(0, 5) == 0);
      br = ($urandom_range(0, 2) == 0);
      cyc(r, en, i, lo, hi, 8'($urandom), br, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
